mem_preloader: RTL and testbench
================================

# mem_preloader

Synthesizable replacement for hand-driven main_mem initialisation. Consumes a valid/ready element stream of segment descriptors and payload, writes the payload into the main_mem write port, then raises `start` and hands that write port to the dmac. Parametrised in element width, address width, memory depth and segment count. Sits between the host/FPGA loading interface and `dpr` main_mem, in front of `top`/`cpu`/`dmac`.

## Interface
- ELEMENT_BITS, 8, width of one stream beat and one memory word
- ADDR_BITS, 11, main_mem address width; also the width of the descriptor address and count fields
- MEM_DEPTH, 2048, number of valid main_mem words (≤ 2^ADDR_BITS)
- MAX_SEGMENTS, 8, segments accepted before an automatic finish
- HDR_WORDS (localparam), ceil(ADDR_BITS/ELEMENT_BITS), beats per descriptor field

Ports:
- fpga_clk  in  1  system clock, all logic on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat accepted when s_valid & s_ready at a rising edge
- s_data  in  ELEMENT_BITS  stream beat
- dmac_we  in  1  dmac write enable, forwarded once start=1
- dmac_address  in  ADDR_BITS  dmac write address
- dmac_data  in  ELEMENT_BITS  dmac write data
- mem_we  out  1  to main_mem cs_in/we_in
- mem_address  out  ADDR_BITS  to main_mem address_in
- mem_data  out  ELEMENT_BITS  to main_mem data_in
- start  out  1  level; 0 = loader owns the write port, 1 = load complete, dmac owns it
- segments_done  out  $clog2(MAX_SEGMENTS+1)  completed segments
- err  out  1  sticky; a write past MEM_DEPTH-1 was dropped

## Operation
- Stream format per segment: ADDR field (HDR_WORDS beats, LS beat first), COUNT field (HDR_WORDS beats, LS first), then COUNT payload beats. Bits of the top beat above ADDR_BITS are ignored.
- A COUNT of 0 is the terminator and finishes the load. No payload follows it.
- FSM states: IDLE→ADDR (first beat accepted), ADDR→COUNT after HDR_WORDS beats, COUNT→DATA if the field is nonzero, COUNT→DONE if it is zero, DATA→ADDR after COUNT payload beats, or DATA→DONE when segments_done reaches MAX_SEGMENTS. DONE is absorbing until reset.
- The IDLE/ADDR transition consumes the beat: IDLE accepts the first ADDR beat itself.
- s_ready = 1 in IDLE, ADDR, COUNT and DATA; 0 in DONE.
- Payload beat k of a segment writes address ADDR+k.
- If ADDR+k ≥ MEM_DEPTH, the beat is still consumed, no write is issued and err is set. err stays set until reset.
- segments_done increments on the last payload beat of each segment and saturates at MAX_SEGMENTS.
- Port mux is combinational on the start register. start=0: mem_* = registered loader write. start=1: mem_* = dmac_*.
- Reset values: s_ready 0 during reset and 1 from the first edge after release, mem_we 0, mem_address 0, mem_data 0, start 0, segments_done 0, err 0, state IDLE.

## Timing
- Payload beat accepted at edge N: mem_we/mem_address/mem_data are valid during cycle N→N+1, and main_mem samples them at edge N+1. At most one write is in flight. There are no bubbles, so back-to-back beats give back-to-back writes.
- Descriptor beats produce no write; mem_we=0 in those cycles.
- Last terminator beat accepted at edge T: start=1 from edge T+1. The last payload write (edge ≤ T−HDR_WORDS·2+1) has already been committed, so there is no overlap with the dmac.
- Auto-finish: last payload beat of segment MAX_SEGMENTS accepted at edge M. Its write commits at M+1, start=1 from M+2, and the loader mem_we is forced 0 in cycle M+1→M+2 after the write.
- s_valid low stalls the FSM at any point with no side effects. Partial header fields are held.
- reset_n asserted mid-load: all state clears immediately, and words already written stay in main_mem. After release the loader restarts in IDLE and expects a fresh descriptor.

## Test plan
- Three segments (defaults): ADDR 0x028/COUNT 64 payload 4,3,2…; ADDR 0x068/COUNT 64; ADDR 0x000/COUNT 16 inputs 1..8,7..1,8; then terminator 0x00,0x00. Required: 144 writes at the stated addresses, main_mem readback matches, segments_done=3, start rises one cycle after the last terminator beat, err=0.
- s_valid toggled randomly (50%) over the same stream. Required: identical memory contents and write order, and mem_we only in cycles after an accepted payload beat.
- ADDR 2046/COUNT 4 with MEM_DEPTH=2047. Required: writes at 2046 only, three beats consumed without writes, err=1, and the FSM continues to the next segment.
- MAX_SEGMENTS=2 with two ADDR 0x100/COUNT 1 segments and no terminator. Required: start=1 two edges after the second payload beat, and s_ready=0 thereafter.
- After start=1, drive dmac_we=1, dmac_address=0x0B0, dmac_data=0x5A. Required: mem_* mirror the dmac inputs in the same cycle, and s_valid is ignored.
- reset_n pulsed low for one cycle after 10 payload beats of a COUNT 64 segment. Required: all outputs return to reset values asynchronously, and a fresh descriptor after release loads correctly.

Source files
------------

// File: rtl/mem_preloader_if.sv
// Valid/ready element stream carrying segment descriptors and payload into mem_preloader.
interface mem_preloader_if #(
    parameter int ELEMENT_BITS = 8
);
    logic                    s_valid;
    logic                    s_ready;
    logic [ELEMENT_BITS-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/mem_preloader.sv
// Streams segment descriptors + payload into the main_mem write port, then raises start
// and hands the write port over to the dmac.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for the first ADDR beat of a load
// ST_ADDR  | collecting the remaining ADDR field beats (LS beat first)
// ST_COUNT | collecting the COUNT field beats; zero count terminates the load
// ST_DATA  | consuming payload beats, one main_mem write per in-range beat
// ST_DONE  | load finished; start rises once no loader write is in flight
module mem_preloader #(
    parameter int ELEMENT_BITS = 8,
    parameter int ADDR_BITS    = 11,
    parameter int MEM_DEPTH    = 2048,
    parameter int MAX_SEGMENTS = 8
) (
    input  logic                                 fpga_clk,
    input  logic                                 reset_n,
    mem_preloader_if.slave                       s,
    input  logic                                 dmac_we,
    input  logic [ADDR_BITS-1:0]                 dmac_address,
    input  logic [ELEMENT_BITS-1:0]              dmac_data,
    output logic                                 mem_we,
    output logic [ADDR_BITS-1:0]                 mem_address,
    output logic [ELEMENT_BITS-1:0]              mem_data,
    output logic                                 start,
    output logic [$clog2(MAX_SEGMENTS+1)-1:0]    segments_done,
    output logic                                 err
);

    localparam int HDR_WORDS = (ADDR_BITS + ELEMENT_BITS - 1) / ELEMENT_BITS;
    localparam int HDR_BITS  = HDR_WORDS * ELEMENT_BITS;
    localparam int BEAT_BITS = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam int SEG_BITS  = $clog2(MAX_SEGMENTS + 1);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(HDR_WORDS - 1);
    localparam logic [SEG_BITS-1:0]  SEG_MAX   = SEG_BITS'(MAX_SEGMENTS);
    localparam logic [ADDR_BITS:0]   DEPTH     = (ADDR_BITS + 1)'(MEM_DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_COUNT = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]              state_q;
    logic                    ready_q;
    logic [BEAT_BITS-1:0]    beat_q;
    logic [HDR_BITS-1:0]     hdr_q;
    logic [HDR_BITS-1:0]     hdr_next;
    logic [ADDR_BITS-1:0]    base_q;
    logic [ADDR_BITS-1:0]    remain_q;
    logic [ADDR_BITS:0]      wr_ptr_q;
    logic                    loader_we_q;
    logic [ADDR_BITS-1:0]    loader_addr_q;
    logic [ELEMENT_BITS-1:0] loader_data_q;
    logic                    start_q;
    logic                    err_q;
    logic [SEG_BITS-1:0]     seg_q;

    logic                    accept;
    logic                    field_done;
    logic [ADDR_BITS-1:0]    field;

    assign s.s_ready  = ready_q && (state_q != ST_DONE);
    assign accept     = s.s_valid && s.s_ready;
    assign field_done = (beat_q == LAST_BEAT);
    assign field      = hdr_next[ADDR_BITS-1:0];

    // Partially collected fields stay in hdr_q across s_valid stalls.
    always_comb begin
        hdr_next = hdr_q;
        hdr_next[beat_q*ELEMENT_BITS +: ELEMENT_BITS] = s.s_data;
    end

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            beat_q        <= '0;
            hdr_q         <= '0;
            base_q        <= '0;
            remain_q      <= '0;
            wr_ptr_q      <= '0;
            loader_we_q   <= 1'b0;
            loader_addr_q <= '0;
            loader_data_q <= '0;
            start_q       <= 1'b0;
            err_q         <= 1'b0;
            seg_q         <= '0;
        end else begin
            ready_q     <= 1'b1;
            loader_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ADDR, ST_COUNT: begin
                    if (accept) begin
                        hdr_q  <= hdr_next;
                        beat_q <= field_done ? '0 : beat_q + 1'b1;
                        if (field_done) begin
                            if (state_q == ST_COUNT) begin
                                remain_q <= field;
                                wr_ptr_q <= {1'b0, base_q};
                                state_q  <= (field == '0) ? ST_DONE : ST_DATA;
                            end else begin
                                base_q  <= field;
                                state_q <= ST_COUNT;
                            end
                        end else if (state_q == ST_IDLE) begin
                            state_q <= ST_ADDR;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        // Out-of-range beats are swallowed so the stream stays aligned.
                        if (wr_ptr_q < DEPTH) begin
                            loader_we_q   <= 1'b1;
                            loader_addr_q <= wr_ptr_q[ADDR_BITS-1:0];
                            loader_data_q <= s.s_data;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (remain_q == ADDR_BITS'(1)) begin
                            if (seg_q != SEG_MAX) begin
                                seg_q <= seg_q + 1'b1;
                            end
                            state_q <= (seg_q >= SEG_MAX - 1'b1) ? ST_DONE : ST_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    // Hold off the handover until the final loader write has committed.
                    if (!loader_we_q) begin
                        start_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we        = start_q ? dmac_we      : loader_we_q;
    assign mem_address   = start_q ? dmac_address : loader_addr_q;
    assign mem_data      = start_q ? dmac_data    : loader_data_q;
    assign start         = start_q;
    assign segments_done = seg_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_preloader.sv
// Randomized self-checking bench for mem_preloader: three instances (defaults, short depth,
// two-segment limit) share one stream driver and one cycle-level write monitor.
module tb_mem_preloader;
    localparam int EB = 8;
    localparam int AB = 11;

    logic fpga_clk = 1'b0;
    logic reset_n  = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    logic          dmac_we      = 1'b0;
    logic [AB-1:0] dmac_address = '0;
    logic [EB-1:0] dmac_data    = '0;

    logic          drv_valid = 1'b0;
    logic [EB-1:0] drv_data  = '0;
    logic          drv_pay   = 1'b0;
    logic          drv_inr   = 1'b0;
    logic [AB-1:0] drv_waddr = '0;
    int            sel       = 0;
    logic          mon_en    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    mem_preloader_if #(.ELEMENT_BITS(EB)) if_a ();
    mem_preloader_if #(.ELEMENT_BITS(EB)) if_d ();
    mem_preloader_if #(.ELEMENT_BITS(EB)) if_m ();

    assign if_a.s_valid = drv_valid && (sel == 0);
    assign if_d.s_valid = drv_valid && (sel == 1);
    assign if_m.s_valid = drv_valid && (sel == 2);
    assign if_a.s_data  = drv_data;
    assign if_d.s_data  = drv_data;
    assign if_m.s_data  = drv_data;

    logic we_a, we_d, we_m, start_a, start_d, start_m, err_a, err_d, err_m;
    logic [AB-1:0] addr_a, addr_d, addr_m;
    logic [EB-1:0] data_a, data_d, data_m;
    logic [3:0] seg_a, seg_d;
    logic [1:0] seg_m;

    mem_preloader dut_a (
        .fpga_clk(fpga_clk), .reset_n(reset_n), .s(if_a.slave),
        .dmac_we(dmac_we), .dmac_address(dmac_address), .dmac_data(dmac_data),
        .mem_we(we_a), .mem_address(addr_a), .mem_data(data_a),
        .start(start_a), .segments_done(seg_a), .err(err_a));

    mem_preloader #(.MEM_DEPTH(2047)) dut_d (
        .fpga_clk(fpga_clk), .reset_n(reset_n), .s(if_d.slave),
        .dmac_we(dmac_we), .dmac_address(dmac_address), .dmac_data(dmac_data),
        .mem_we(we_d), .mem_address(addr_d), .mem_data(data_d),
        .start(start_d), .segments_done(seg_d), .err(err_d));

    mem_preloader #(.MAX_SEGMENTS(2)) dut_m (
        .fpga_clk(fpga_clk), .reset_n(reset_n), .s(if_m.slave),
        .dmac_we(dmac_we), .dmac_address(dmac_address), .dmac_data(dmac_data),
        .mem_we(we_m), .mem_address(addr_m), .mem_data(data_m),
        .start(start_m), .segments_done(seg_m), .err(err_m));

    logic          cur_we, cur_start, cur_err, cur_ready;
    logic [AB-1:0] cur_addr;
    logic [EB-1:0] cur_data;
    logic [3:0]    cur_seg;

    always_comb begin
        cur_we = we_a; cur_addr = addr_a; cur_data = data_a; cur_start = start_a;
        cur_err = err_a; cur_seg = seg_a; cur_ready = if_a.s_ready;
        if (sel == 1) begin
            cur_we = we_d; cur_addr = addr_d; cur_data = data_d; cur_start = start_d;
            cur_err = err_d; cur_seg = seg_d; cur_ready = if_d.s_ready;
        end else if (sel == 2) begin
            cur_we = we_m; cur_addr = addr_m; cur_data = data_m; cur_start = start_m;
            cur_err = err_m; cur_seg = {2'b00, seg_m}; cur_ready = if_m.s_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference stream: beats plus the write each payload beat must produce.
    logic [EB-1:0]    b_data[$];
    bit               b_pay[$];
    bit               b_inr[$];
    logic [AB-1:0]    b_addr[$];
    logic [AB+EB-1:0] exp_wq[$];
    logic [EB-1:0]    exp_mem [0:2047];
    bit               exp_set [0:2047];

    task automatic clear_stream();
        b_data.delete(); b_pay.delete(); b_inr.delete(); b_addr.delete(); exp_wq.delete();
        for (int i = 0; i < 2048; i++) exp_set[i] = 1'b0;
    endtask

    task automatic push_beat(input logic [EB-1:0] d, input bit pay, input bit inr, input logic [AB-1:0] a);
        b_data.push_back(d); b_pay.push_back(pay); b_inr.push_back(inr); b_addr.push_back(a);
    endtask

    // Two beats per field, LS first; junk above bit 10 must be ignored by the DUT.
    task automatic add_field(input int value);
        logic [4:0] junk;
        junk = 5'($urandom);
        push_beat(8'(value & 255), 1'b0, 1'b0, '0);
        push_beat({junk, 3'((value >> 8) & 7)}, 1'b0, 1'b0, '0);
    endtask

    task automatic add_pay(input int base, input int k, input logic [EB-1:0] d, input int depth);
        int a;
        bit inr;
        a = base + k;
        inr = (a < depth);
        push_beat(d, 1'b1, inr, AB'(a));
        if (inr) begin
            exp_mem[a] = d;
            exp_set[a] = 1'b1;
            exp_wq.push_back({AB'(a), d});
        end
    endtask

    task automatic add_seg_rand(input int base, input int cnt, input int depth);
        add_field(base);
        add_field(cnt);
        for (int k = 0; k < cnt; k++) add_pay(base, k, 8'($urandom), depth);
    endtask

    task automatic add_term();
        add_field(int'($urandom_range(0, 2047)));
        add_field(0);
    endtask

    // Monitor: beat accepted at edge N must show as a write in cycle N..N+1, nothing else.
    logic             exp_we   = 1'b0;
    logic [AB-1:0]    exp_addr = '0;
    logic [EB-1:0]    exp_data = '0;
    logic [AB+EB-1:0] wr_q[$];
    logic [EB-1:0]    mon_mem [0:2047];

    always @(negedge fpga_clk) begin
        if (mon_en && !cur_start) begin
            chk("mon_we", 32'(cur_we), 32'(exp_we));
            if (exp_we) begin
                chk("mon_addr", 32'(cur_addr), 32'(exp_addr));
                chk("mon_data", 32'(cur_data), 32'(exp_data));
            end
            if (cur_we) begin
                wr_q.push_back({cur_addr, cur_data});
                mon_mem[cur_addr] = cur_data;
            end
        end
        exp_we   = mon_en && drv_valid && cur_ready && drv_pay && drv_inr;
        exp_addr = drv_waddr;
        exp_data = drv_data;
    end

    task automatic send(input int first, input int last, input bit rnd);
        int idx;
        int guard;
        bit acc;
        idx = first;
        guard = 0;
        while (idx < last && guard < 4000) begin
            drv_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drv_data  = b_data[idx];
            drv_pay   = b_pay[idx];
            drv_inr   = b_inr[idx];
            drv_waddr = b_addr[idx];
            @(negedge fpga_clk);
            acc = drv_valid && cur_ready;
            @(posedge fpga_clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        drv_valid = 1'b0;
        drv_pay   = 1'b0;
        chk("send_beats", 32'(idx), 32'(last));
    endtask

    task automatic do_reset();
        @(negedge fpga_clk);
        reset_n = 1'b0;
        @(negedge fpga_clk);
        reset_n = 1'b1;
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic check_order(input string tag, input int base);
        chk({tag, "_count"}, 32'(wr_q.size() - base), 32'(exp_wq.size()));
        for (int i = 0; i < exp_wq.size(); i++) begin
            if (base + i < wr_q.size()) chk({tag, "_order"}, 32'(wr_q[base + i]), 32'(exp_wq[i]));
        end
    endtask

    // Terminator accepted at edge T: start low during T..T+1, high after T+1.
    task automatic check_term_start(input string tag);
        @(negedge fpga_clk);
        chk({tag, "_start_early"}, 32'(cur_start), 32'd0);
        chk({tag, "_ready_done"}, 32'(cur_ready), 32'd0);
        @(posedge fpga_clk);
        #1;
        chk({tag, "_start"}, 32'(cur_start), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;

        // Reset values
        #12;
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_start", 32'(start_a), 32'd0);
        chk("rst_seg", 32'(seg_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_ready", 32'(if_a.s_ready), 32'd0);
        @(negedge fpga_clk);
        reset_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(if_a.s_ready), 32'd0);
        @(posedge fpga_clk);
        #1;
        chk("rel_ready_after_edge", 32'(if_a.s_ready), 32'd1);

        // Three segments then terminator, continuous valid
        sel = 0;
        clear_stream();
        add_seg_rand(12'h028, 64, 2048);
        add_seg_rand(12'h068, 64, 2048);
        add_field(0);
        add_field(16);
        for (int k = 0; k < 16; k++) add_pay(0, k, (k < 8) ? 8'(k + 1) : (k < 15) ? 8'(15 - k) : 8'd8, 2048);
        add_term();
        n = b_data.size();
        base = wr_q.size();
        mon_en = 1'b1;
        send(0, n, 1'b0);
        check_term_start("t1");
        mon_en = 1'b0;
        check_order("t1", base);
        chk("t1_seg", 32'(cur_seg), 32'd3);
        chk("t1_err", 32'(cur_err), 32'd0);
        for (int a = 0; a < 2048; a++) begin
            if (exp_set[a]) chk("t1_mem", 32'(mon_mem[a]), 32'(exp_mem[a]));
        end

        // dmac owns the port once start is high; stream is ignored
        dmac_we = 1'b1; dmac_address = 11'h0B0; dmac_data = 8'h5A;
        drv_valid = 1'b1; drv_data = 8'($urandom);
        #1;
        chk("dmac_we", 32'(cur_we), 32'd1);
        chk("dmac_addr", 32'(cur_addr), 32'h0B0);
        chk("dmac_data", 32'(cur_data), 32'h5A);
        chk("dmac_ready", 32'(cur_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dmac_we = 1'($urandom); dmac_address = 11'($urandom); dmac_data = 8'($urandom);
            #3;
            chk("dmac_mirror_we", 32'(cur_we), 32'(dmac_we));
            chk("dmac_mirror_addr", 32'(cur_addr), 32'(dmac_address));
            chk("dmac_mirror_data", 32'(cur_data), 32'(dmac_data));
            @(posedge fpga_clk);
            #1;
        end
        chk("dmac_seg_hold", 32'(cur_seg), 32'd3);
        drv_valid = 1'b0; dmac_we = 1'b0;

        // Same stream with s_valid toggled at random
        do_reset();
        base = wr_q.size();
        mon_en = 1'b1;
        send(0, n, 1'b1);
        check_term_start("t2");
        mon_en = 1'b0;
        check_order("t2", base);
        chk("t2_seg", 32'(cur_seg), 32'd3);
        for (int a = 0; a < 2048; a++) begin
            if (exp_set[a]) chk("t2_mem", 32'(mon_mem[a]), 32'(exp_mem[a]));
        end

        // Writes past MEM_DEPTH-1 are dropped, err is sticky, next segment still loads
        sel = 1;
        do_reset();
        clear_stream();
        add_seg_rand(2046, 4, 2047);
        add_seg_rand(12'h010, 3, 2047);
        add_term();
        base = wr_q.size();
        mon_en = 1'b1;
        send(0, b_data.size(), 1'b1);
        check_term_start("t3");
        mon_en = 1'b0;
        check_order("t3", base);
        chk("t3_err", 32'(cur_err), 32'd1);
        chk("t3_seg", 32'(cur_seg), 32'd2);

        // Auto-finish after MAX_SEGMENTS=2 segments
        sel = 2;
        do_reset();
        clear_stream();
        add_seg_rand(12'h100, 1, 2048);
        add_seg_rand(12'h100, 1, 2048);
        base = wr_q.size();
        mon_en = 1'b1;
        send(0, b_data.size(), 1'b0);
        @(negedge fpga_clk);
        chk("t4_last_we", 32'(cur_we), 32'd1);
        chk("t4_start_m1", 32'(cur_start), 32'd0);
        chk("t4_ready_m1", 32'(cur_ready), 32'd0);
        @(negedge fpga_clk);
        chk("t4_we_forced0", 32'(cur_we), 32'd0);
        chk("t4_start_m2", 32'(cur_start), 32'd0);
        @(negedge fpga_clk);
        chk("t4_start", 32'(cur_start), 32'd1);
        mon_en = 1'b0;
        drv_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge fpga_clk);
            chk("t4_ready_done", 32'(cur_ready), 32'd0);
        end
        drv_valid = 1'b0;
        check_order("t4", base);
        chk("t4_seg", 32'(cur_seg), 32'd2);

        // Reset pulse in the middle of a payload burst, then a fresh load
        sel = 0;
        do_reset();
        clear_stream();
        add_seg_rand(12'h200, 64, 2048);
        mon_en = 1'b1;
        send(0, 14, 1'b0);
        mon_en = 1'b0;
        chk("t5_pre_we", 32'(cur_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_we", 32'(cur_we), 32'd0);
        chk("t5_async_addr", 32'(cur_addr), 32'd0);
        chk("t5_async_data", 32'(cur_data), 32'd0);
        chk("t5_async_start", 32'(cur_start), 32'd0);
        chk("t5_async_seg", 32'(cur_seg), 32'd0);
        chk("t5_async_err", 32'(cur_err), 32'd0);
        chk("t5_async_ready", 32'(cur_ready), 32'd0);
        @(negedge fpga_clk);
        reset_n = 1'b1;
        @(posedge fpga_clk);
        #1;
        clear_stream();
        add_seg_rand(12'h300, 5, 2048);
        add_term();
        base = wr_q.size();
        mon_en = 1'b1;
        send(0, b_data.size(), 1'b1);
        check_term_start("t5");
        mon_en = 1'b0;
        check_order("t5", base);
        chk("t5_seg", 32'(cur_seg), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
